// File: rtl/prod_accum_pkg.sv
// Shared types and arithmetic for the product accumulator
// and future MAC stages.
package prod_accum_pkg;

  localparam int PROD_W_DEF = 36;
  localparam int ACC_W_DEF  = 48;
  localparam int LEN_DEF    = 16;
  localparam int MAX_W      = 64;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  typedef struct packed {
    logic             ovf;
    logic [MAX_W-1:0] sum;
  } sat_sum_t;

  // a and b must be below 2**w; result clips to w ones
  function automatic sat_sum_t sat_add(
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b,
    input int unsigned      w
  );
    logic [MAX_W:0]   s;
    logic [MAX_W-1:0] ones;
    sat_sum_t         r;
    s     = {1'b0, a} + {1'b0, b};
    ones  = {MAX_W{1'b1}} >> (MAX_W - w);
    r.ovf = |(s >> w);
    r.sum = r.ovf ? ones : s[MAX_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/prod_accum_out_hold_reg.sv
// Single-entry valid/ready result register;
// flags a result that arrives while full and stalled.
module prod_accum_out_hold_reg #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_sat,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         sat,
  output logic         drop
);

  assign drop = load & valid & ~ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
      sat   <= 1'b0;
    end else if (load & (~valid | ready)) begin
      data  <= load_data;
      sat   <= load_sat;
      valid <= 1'b1;
    end else if (valid & ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/prod_accum.sv
// Frame accumulator for the multiplier product stream;
// sums LEN products per frame into a held result.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int LEN    = LEN_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  input  logic              frame_start,
  output logic [ACC_W-1:0]  sum_out,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic              sat,
  output logic              overrun,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             sat_pending;
  sat_sum_t         add_r;
  logic [ACC_W-1:0] acc_sum;
  logic             done;
  logic             done_sat;
  logic             drop;

  always_comb begin
    add_r    = sat_add(MAX_W'(acc), MAX_W'(prod_in), ACC_W);
    acc_sum  = ACC_W'(add_r.sum);
    done_sat = sat_pending | add_r.ovf;
    done     = (state == ACCUM) & prod_valid &
               ~frame_start & (count == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      count       <= '0;
      sat_pending <= 1'b0;
      frame_err   <= 1'b0;
    end else if (prod_valid) begin
      unique case (state)
        IDLE: begin
          if (frame_start) begin
            acc         <= ACC_W'(prod_in);
            count       <= CNT_W'(1);
            sat_pending <= 1'b0;
            state       <= ACCUM;
          end
        end
        ACCUM: begin
          if (frame_start) begin
            acc         <= ACC_W'(prod_in);
            count       <= CNT_W'(1);
            sat_pending <= 1'b0;
            frame_err   <= 1'b1;
          end else begin
            acc         <= acc_sum;
            sat_pending <= done_sat;
            if (done) begin
              count <= '0;
              state <= IDLE;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun <= 1'b0;
    else if (drop) overrun <= 1'b1;
  end

  prod_accum_out_hold_reg #(
    .W(ACC_W)
  ) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (done),
    .load_data(acc_sum),
    .load_sat (done_sat),
    .ready    (sum_ready),
    .data     (sum_out),
    .valid    (sum_valid),
    .sat      (sat),
    .drop     (drop)
  );

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum with LEN=4, ACC_W=37
// so that saturation is reachable.
module tb_prod_accum;

  localparam int PW = 36;
  localparam int AW = 37;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] prod_in;
  logic          prod_valid;
  logic          frame_start;
  logic [AW-1:0] sum_out;
  logic          sum_valid;
  logic          sum_ready;
  logic          sat;
  logic          overrun;
  logic          frame_err;

  int checks = 0;
  int failures = 0;

  prod_accum #(
    .PROD_W(PW),
    .LEN   (4),
    .ACC_W (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .frame_start(frame_start),
    .sum_out    (sum_out),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .sat        (sat),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [PW-1:0] p, input logic fs);
    @(negedge clk);
    prod_in     = p;
    prod_valid  = 1'b1;
    frame_start = fs;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      prod_valid  = 1'b0;
      frame_start = 1'b0;
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    prod_in = '0;
    prod_valid = 1'b0;
    frame_start = 1'b0;
    sum_ready = 1'b1;
    #1;
    checks++;
    if ({sum_out, sum_valid, sat, overrun, frame_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {sum_out, sum_valid, sat, overrun, frame_err});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    send(36'd1, 1'b1);
    send(36'd2, 1'b0);
    send(36'd3, 1'b0);
    send(36'd4, 1'b0);
    checks++;
    if (sum_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_early_valid got=%b exp=0", sum_valid);
    end
    edge_sample();
    checks++;
    if (sum_valid !== 1'b1 || sum_out !== 37'd10) begin
      failures++;
      $display("FAIL basic_sum got=%0d/v%b exp=10/v1",
               sum_out, sum_valid);
    end
    checks++;
    if ({sat, overrun, frame_err} !== 3'b000) begin
      failures++;
      $display("FAIL basic_flags got=%b exp=000",
               {sat, overrun, frame_err});
    end
    gap(1);
    edge_sample();
    checks++;
    if (sum_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_valid_drop got=%b exp=0", sum_valid);
    end
  endtask

  task automatic test_gaps();
    send(36'd1, 1'b1);
    gap(3);
    send(36'd2, 1'b0);
    gap(3);
    send(36'd3, 1'b0);
    gap(3);
    send(36'd4, 1'b0);
    edge_sample();
    checks++;
    if (sum_valid !== 1'b1 || sum_out !== 37'd10) begin
      failures++;
      $display("FAIL gaps_sum got=%0d/v%b exp=10/v1",
               sum_out, sum_valid);
    end
    gap(2);
  endtask

  task automatic test_saturation();
    logic [PW-1:0] big;
    logic [AW-1:0] ones;
    big  = '1;
    ones = '1;
    send(big, 1'b1);
    send(big, 1'b0);
    send(big, 1'b0);
    send(big, 1'b0);
    edge_sample();
    checks++;
    if (sum_valid !== 1'b1 || sum_out !== ones || sat !== 1'b1) begin
      failures++;
      $display("FAIL sat_sum got=%h/s%b exp=%h/s1",
               sum_out, sat, ones);
    end
    gap(1);
    send(36'd1, 1'b1);
    send(36'd1, 1'b0);
    send(36'd1, 1'b0);
    send(36'd1, 1'b0);
    edge_sample();
    checks++;
    if (sum_out !== 37'd4 || sat !== 1'b0) begin
      failures++;
      $display("FAIL sat_clear got=%0d/s%b exp=4/s0", sum_out, sat);
    end
    gap(2);
  endtask

  task automatic test_restart_simul();
    send(36'd1, 1'b1);
    send(36'd2, 1'b0);
    send(36'd5, 1'b1);
    edge_sample();
    checks++;
    if (frame_err !== 1'b1) begin
      failures++;
      $display("FAIL restart_frame_err got=%b exp=1", frame_err);
    end
    send(36'd6, 1'b0);
    send(36'd7, 1'b0);
    send(36'd8, 1'b0);
    edge_sample();
    checks++;
    if (sum_valid !== 1'b1 || sum_out !== 37'd26) begin
      failures++;
      $display("FAIL restart_sum got=%0d/v%b exp=26/v1",
               sum_out, sum_valid);
    end
    send(36'd1, 1'b1);
    sum_ready = 1'b0;
    send(36'd1, 1'b0);
    send(36'd1, 1'b0);
    send(36'd1, 1'b0);
    checks++;
    if (sum_out !== 37'd26 || sum_valid !== 1'b1) begin
      failures++;
      $display("FAIL hold_stable got=%0d/v%b exp=26/v1",
               sum_out, sum_valid);
    end
    sum_ready = 1'b1;
    edge_sample();
    checks++;
    if (sum_valid !== 1'b1 || sum_out !== 37'd4 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL simul_xfer got=%0d/v%b/o%b exp=4/v1/o0",
               sum_out, sum_valid, overrun);
    end
    gap(1);
    edge_sample();
    checks++;
    if (sum_valid !== 1'b0) begin
      failures++;
      $display("FAIL simul_drop got=%b exp=0", sum_valid);
    end
  endtask

  task automatic test_overrun();
    @(negedge clk);
    sum_ready = 1'b0;
    send(36'd1, 1'b1);
    send(36'd2, 1'b0);
    send(36'd3, 1'b0);
    send(36'd4, 1'b0);
    edge_sample();
    checks++;
    if (sum_valid !== 1'b1 || sum_out !== 37'd10 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL ovr_first got=%0d/v%b/o%b exp=10/v1/o0",
               sum_out, sum_valid, overrun);
    end
    send(36'd5, 1'b1);
    send(36'd6, 1'b0);
    send(36'd7, 1'b0);
    send(36'd8, 1'b0);
    edge_sample();
    checks++;
    if (sum_out !== 37'd10 || sum_valid !== 1'b1 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_second got=%0d/v%b/o%b exp=10/v1/o1",
               sum_out, sum_valid, overrun);
    end
    gap(2);
    @(negedge clk);
    sum_ready = 1'b1;
    edge_sample();
    checks++;
    if (sum_valid !== 1'b0 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_release got=v%b/o%b exp=v0/o1",
               sum_valid, overrun);
    end
  endtask

  task automatic test_async_reset();
    send(36'd1, 1'b1);
    send(36'd2, 1'b0);
    edge_sample();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sum_out, sum_valid, sat, overrun, frame_err} !== '0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0",
               {sum_out, sum_valid, sat, overrun, frame_err});
    end
    @(negedge clk);
    prod_valid = 1'b0;
    frame_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(36'd9, 1'b0);
    send(36'd9, 1'b0);
    send(36'd9, 1'b0);
    send(36'd9, 1'b0);
    edge_sample();
    checks++;
    if (sum_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignore got=%b exp=0", sum_valid);
    end
    send(36'd1, 1'b1);
    send(36'd2, 1'b0);
    send(36'd3, 1'b0);
    send(36'd4, 1'b0);
    edge_sample();
    checks++;
    if (sum_valid !== 1'b1 || sum_out !== 37'd10 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_sum got=%0d/v%b/e%b exp=10/v1/e0",
               sum_out, sum_valid, frame_err);
    end
    gap(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_saturation();
    test_restart_simul();
    test_overrun();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
